// File: rtl/fp_pkg.sv
// Shared constants, state encoding and packing helper for the FP normalise/round stage.
package fp_pkg;

  localparam int MAN_W    = 24;                    // mantissa width including hidden bit
  localparam int EXP_W    = 8;                     // biased exponent width
  localparam int OUT_W    = 1 + EXP_W + MAN_W - 1; // packed single-precision word
  localparam int EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

  // Canonical special encodings (positive sign)
  localparam logic [OUT_W-1:0] INF_POS = {1'b0, EXP_ALL1, {(MAN_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] QNAN    = {1'b0, EXP_ALL1, 1'b1, {(MAN_W-2){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  // Assemble {sign, exponent, fraction} into the output word
  function automatic logic [OUT_W-1:0] pack_word(input logic             sign,
                                                 input logic [EXP_W-1:0] exp,
                                                 input logic [MAN_W-2:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_norm_round_if.sv
// Load/result bundle between the upstream datapath and fp_norm_round.
// master: the producer of raw results; slave: the normalise/round stage.
interface fp_norm_round_if;
  import fp_pkg::*;

  logic             load;
  logic             in_carry;
  logic [MAN_W-1:0] in_man;
  logic [EXP_W-1:0] in_exp;
  logic             in_sign;
  logic [2:0]       in_grs;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] out_float;

  modport master (
    output load, in_carry, in_man, in_exp, in_sign, in_grs,
    input  busy, done, out_float
  );

  modport slave (
    input  load, in_carry, in_man, in_exp, in_sign, in_grs,
    output busy, done, out_float
  );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational rounding and packing of a normalised mantissa.
// Rounds to nearest-even from G/R/S; a mantissa that wraps from all-ones
// becomes 1000...0 with the exponent bumped. ovf flags an exponent that
// reached all-ones so the caller can substitute infinity.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W-1:0] man,
  input  logic [EXP_W:0]   exp,
  input  logic             sign,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic [OUT_W-1:0] word,
  output logic             ovf
);

  logic             inc;
  logic [MAN_W:0]   man_sum;
  logic [EXP_W:0]   exp_r;
  logic             hidden;
  logic [EXP_W-1:0] exp_field;

  // Increment decision, mantissa carry into the exponent, and packing
  always_comb begin
    inc       = g & (r | s | man[0]);
    man_sum   = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    exp_r     = exp + {{EXP_W{1'b0}}, man_sum[MAN_W]};
    // A result without a hidden bit is a (signed) zero: exponent field is 0
    hidden    = man_sum[MAN_W] | man_sum[MAN_W-1];
    exp_field = hidden ? exp_r[EXP_W-1:0] : '0;
    ovf       = (exp_r >= {1'b0, EXP_ALL1});
    // On wrap man_sum is 1_000..0, so the low fraction bits are already zero
    word      = pack_word(sign, exp_field, man_sum[MAN_W-2:0]);
  end

endmodule

// File: rtl/fp_norm_round.sv
// Normalise / round / pack stage for the iterative FP datapath.
// A raw result is captured on load, normalised one bit per cycle, rounded
// and packed into IEEE-754 single precision; out_float holds until the
// next accepted load.
// Optional build macro FP_ROUND_EN: defined -> round-to-nearest-even,
// undefined -> truncate (G/R/S ignored at rounding, same latency).
module fp_norm_round
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           reset,   // synchronous, active-low
  fp_norm_round_if.slave bus
);

  state_t           state_q,   state_d;
  logic [MAN_W-1:0] man_q,     man_d;
  logic [EXP_W:0]   exp_q,     exp_d;     // one extra bit for over/underflow
  logic             carry_q,   carry_d;
  logic             sign_q,    sign_d;
  logic             g_q,       g_d;
  logic             r_q,       r_d;
  logic             s_q,       s_d;
  logic             first_q,   first_d;   // first NORM cycle: carry/special/zero prep
  logic             special_q, special_d; // inf/NaN pass-through, no rounding
  logic             zero_q,    zero_d;    // result is signed zero
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [OUT_W-1:0] out_q,     out_d;

  logic             rnd_g, rnd_r, rnd_s;
  logic [OUT_W-1:0] rnd_word;
  logic             rnd_ovf;

`ifdef FP_ROUND_EN
  assign rnd_g = g_q & ~special_q;
  assign rnd_r = r_q & ~special_q;
  assign rnd_s = s_q & ~special_q;
`else
  assign rnd_g = 1'b0;
  assign rnd_r = 1'b0;
  assign rnd_s = 1'b0;
`endif

  fp_round_rne u_round (
    .man  (man_q),
    .exp  (exp_q),
    .sign (sign_q),
    .g    (rnd_g),
    .r    (rnd_r),
    .s    (rnd_s),
    .word (rnd_word),
    .ovf  (rnd_ovf)
  );

  // Next-state and datapath update for the IDLE/NORM/ROUND/DONE sequence
  always_comb begin
    state_d   = state_q;
    man_d     = man_q;
    exp_d     = exp_q;
    carry_d   = carry_q;
    sign_d    = sign_q;
    g_d       = g_q;
    r_d       = r_q;
    s_d       = s_q;
    first_d   = first_q;
    special_d = special_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    out_d     = out_q;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          man_d     = bus.in_man;
          exp_d     = {1'b0, bus.in_exp};
          carry_d   = bus.in_carry;
          sign_d    = bus.in_sign;
          g_d       = bus.in_grs[2];
          r_d       = bus.in_grs[1];
          s_d       = bus.in_grs[0];
          first_d   = 1'b1;
          special_d = 1'b0;
          zero_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = NORM;
        end
      end

      NORM: begin
        if (first_q) begin
          first_d = 1'b0;
          if (exp_q[EXP_W-1:0] == EXP_ALL1) begin
            special_d = 1'b1;
          end else if (carry_q) begin
            // Right shift with the carry entering the hidden-bit position
            man_d   = {carry_q, man_q[MAN_W-1:1]};
            exp_d   = exp_q + 1'b1;
            g_d     = man_q[0];
            r_d     = g_q;
            s_d     = r_q | s_q;
            carry_d = 1'b0;
          end else if ((man_q == '0) && !g_q) begin
            zero_d = 1'b1;
            exp_d  = '0;
            g_d    = 1'b0;
            r_d    = 1'b0;
            s_d    = 1'b0;
          end
        end else if (special_q || zero_q || man_q[MAN_W-1]) begin
          state_d = ROUND;
        end else if (exp_q <= {{EXP_W{1'b0}}, 1'b1}) begin
          // Would need a denormal: flush to signed zero instead
          zero_d  = 1'b1;
          man_d   = '0;
          exp_d   = '0;
          g_d     = 1'b0;
          r_d     = 1'b0;
          s_d     = 1'b0;
          state_d = ROUND;
        end else begin
          man_d = {man_q[MAN_W-2:0], g_q};
          g_d   = r_q;
          r_d   = 1'b0;
          exp_d = exp_q - 1'b1;
        end
      end

      ROUND: begin
        if (special_q) begin
          out_d = pack_word(sign_q, exp_q[EXP_W-1:0], man_q[MAN_W-2:0]);
        end else if (rnd_ovf) begin
          out_d = pack_word(sign_q, EXP_ALL1, '0);
        end else begin
          out_d = rnd_word;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      man_q     <= '0;
      exp_q     <= '0;
      carry_q   <= 1'b0;
      sign_q    <= 1'b0;
      g_q       <= 1'b0;
      r_q       <= 1'b0;
      s_q       <= 1'b0;
      first_q   <= 1'b0;
      special_q <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      man_q     <= man_d;
      exp_q     <= exp_d;
      carry_q   <= carry_d;
      sign_q    <= sign_d;
      g_q       <= g_d;
      r_q       <= r_d;
      s_q       <= s_d;
      first_q   <= first_d;
      special_q <= special_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      out_q     <= out_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_float = out_q;

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Downstream stage of the iterative FP mantissa/exponent datapath.
- Consumes a raw result: 24-bit mantissa with hidden-bit position, carry bit, 8-bit biased exponent, sign, and guard/round/sticky bits.
- Normalises it with an FSM that shifts one bit per cycle, then rounds and packs it into IEEE-754 single precision.
- Output holds until the next accepted load.

Parameters:
- MAN_W, 24, mantissa width including hidden bit.
- EXP_W, 8, biased exponent width.
- OUT_W, 32, packed output width; must equal 1+EXP_W+MAN_W-1.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge only.
- load  in  1  start strobe; sampled only in IDLE.
- in_carry  in  1  mantissa carry-out (bit MAN_W).
- in_man  in  MAN_W  raw mantissa; bit MAN_W-1 is the hidden-bit position.
- in_exp  in  EXP_W  biased exponent.
- in_sign  in  1  sign.
- in_grs  in  3  guard, round, sticky.
- busy  out  1  high from the load-accept edge until DONE exits.
- done  out  1  one-cycle pulse; out_float is valid from this cycle on.
- out_float  out  OUT_W  packed {sign, exp, man[MAN_W-2:0]}.

Behaviour:
- Reset (reset==0 at the clk edge): state=IDLE, busy=0, done=0, out_float=0; all internal regs cleared. Reset mid-operation aborts the operation with no done pulse.
- IDLE: on load==1, capture all inputs, busy<=1, go to NORM. load is ignored in every other state; there is no queueing.
- NORM, first cycle:
  - in_exp==all-ones: pass through (inf/NaN), go to ROUND with rounding suppressed.
  - carry==1: shift mantissa right by 1 with carry into the MSB; exp+1; old LSB->G, old G->R, R|S->S.
  - carry==0 and mantissa and G all zero: result is signed zero; go to ROUND.
- NORM, every cycle: if hidden bit==1, go to ROUND. Otherwise shift left by 1 (G into LSB, R into G, 0 into R, S kept) and decrement exp.
- Underflow: if exp==1 and hidden bit==0, flush to signed zero and go to ROUND. Denormals are not produced.
- ROUND (1 cycle): apply rounding (see Optional Feature). If the mantissa was all-ones and rounds up, the mantissa becomes 1000...0 and exp+1.
- Overflow: if exp reaches all-ones after the carry step or the rounding step, the result is signed infinity (exp=all-ones, man=0).
- Packing: out_float is registered in ROUND.
- DONE (1 cycle): done=1, busy=0 on exit, then back to IDLE.
- Latency: with k left shifts (k=0 for the carry or zero path), done is high exactly k+3 clk edges after the edge that sampled load.
- Exponent arithmetic uses EXP_W+1 bits internally to detect overflow and underflow.

Optional Feature:
- Macro: FP_ROUND_EN.
- Defined: round-to-nearest-even. Increment when G && (R||S||lsb).
- Undefined: truncate; G/R/S are ignored in ROUND. Latency is unchanged.

Decomposition:
- Package fp_pkg holds: MAN_W, EXP_W, EXP_BIAS=127, EXP_ALL1, the state enum {IDLE, NORM, ROUND, DONE}, and the QNAN/INF constants.
- One natural sub-module: fp_round_rne, purely combinational. Inputs: mantissa, exponent, sign, G/R/S. Outputs: packed word plus overflow flag. The FSM top instantiates it.

Test Plan:
- carry=0, man=0x400000, exp=0x80, grs=0, sign=0 -> one left shift; out_float=0x3F800000; done at load edge+4.
- carry=1, man=0x000000, exp=0x7F -> right shift; out_float=0x40000000; done at load edge+3.
- man=0xFFFFFF, exp=0x7F, grs=3'b100 -> with FP_ROUND_EN: out_float=0x40000000. Without it: out_float=0x3FFFFFFF.
- Special values:
  - carry=1, exp=0xFE -> out_float=0x7F800000.
  - man=0, carry=0, sign=1 -> out_float=0x80000000.
  - man=0x000001, exp=0x05 -> out_float=0x00000000.
- load asserted during NORM with other data -> ignored, first result unchanged. Then reset=0 mid-NORM of the next op -> busy=0, done never pulses, out_float=0.
